// File: rtl/button_event_pkg.sv
// Shared definitions for the button event controller: register map,
// edge-capture mode encodings and default counter width.
package button_event_pkg;

    // Default width of the per-bit debounce counter and DEBOUNCE_TICKS.
    localparam int unsigned CNT_W_DEFAULT = 16;

    // Word offsets of the Avalon-MM register map.
    typedef enum logic [1:0] {
        ADDR_DATA  = 2'd0,
        ADDR_MASK  = 2'd1,
        ADDR_EDGE  = 2'd2,
        ADDR_TICKS = 2'd3
    } reg_addr_e;

    // EDGE_MODE encodings.
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

    // Select which debounced transitions count as a captured event.
    function automatic logic edge_hit(input logic rise, input logic fall,
                                      input int unsigned mode);
        case (mode)
            EDGE_RISE: return rise;
            EDGE_FALL: return fall;
            default:   return rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce_bit.sv
// One button channel: two-flop synchronizer, restartable debounce counter
// and the debounced state flop, with single-cycle rise/fall pulses that are
// asserted in the cycle whose clock edge updates the debounced state.
module button_debounce_bit
    import button_event_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEFAULT,
    parameter logic        INIT_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             raw_i,
    input  logic [CNT_W-1:0] ticks_i,
    output logic             stable_o,
    output logic             rise_o,
    output logic             fall_o
);

    localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

    logic             s1_q;
    logic             s2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   thr;
    logic [CNT_W:0]   cnt_inc;
    logic             fire;

    // Synchronize the asynchronous pin into the clock domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= INIT_LEVEL;
            s2_q <= INIT_LEVEL;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    // Debounce: count consecutive mismatches and accept s2 once the threshold is met.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        // A threshold of zero behaves as one; compare one bit wider so the
        // increment cannot wrap against a full-scale threshold.
        thr      = (ticks_i == '0) ? ONE : {1'b0, ticks_i};
        cnt_inc  = {1'b0, cnt_q} + ONE;
        fire     = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_inc >= thr) begin
            fire     = 1'b1;
            stable_d = s2_q;
            cnt_d    = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_inc[CNT_W-1:0];
        end
        rise_o = fire & s2_q;
        fall_o = fire & ~s2_q;
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_q <= INIT_LEVEL;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Avalon-MM button controller: per-bit debounce, sticky edge capture with
// write-1-to-clear, interrupt mask and a registered level interrupt.
module button_event_ctrl
    import button_event_pkg::*;
#(
    parameter int unsigned          N_BUTTONS     = 9,
    parameter int unsigned          CNT_W         = CNT_W_DEFAULT,
    parameter int unsigned          TICKS_DEFAULT = 50000,
    parameter logic [N_BUTTONS-1:0] INIT_LEVEL    = '1,
    parameter int unsigned          EDGE_MODE     = EDGE_FALL
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [N_BUTTONS-1:0] in_port,
    output logic                 irq
);

    localparam logic [CNT_W-1:0] TICKS_RST = TICKS_DEFAULT[CNT_W-1:0];

    logic [N_BUTTONS-1:0] stable_w;
    logic [N_BUTTONS-1:0] rise_w;
    logic [N_BUTTONS-1:0] fall_w;
    logic [N_BUTTONS-1:0] hit_w;

    logic [N_BUTTONS-1:0] mask_q;
    logic [N_BUTTONS-1:0] mask_d;
    logic [N_BUTTONS-1:0] edge_q;
    logic [N_BUTTONS-1:0] edge_d;
    logic [N_BUTTONS-1:0] clr;
    logic [CNT_W-1:0]     ticks_q;
    logic [CNT_W-1:0]     ticks_d;
    logic [31:0]          readdata_q;
    logic [31:0]          readdata_d;
    logic                 irq_q;
    logic                 irq_d;
    logic                 wr_en;
    reg_addr_e            addr_e;
    logic                 unused_wdata;

    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_bit
        button_debounce_bit #(
            .CNT_W      (CNT_W),
            .INIT_LEVEL (INIT_LEVEL[i])
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_i    (in_port[i]),
            .ticks_i  (ticks_q),
            .stable_o (stable_w[i]),
            .rise_o   (rise_w[i]),
            .fall_o   (fall_w[i])
        );
        assign hit_w[i] = edge_hit(rise_w[i], fall_w[i], EDGE_MODE);
    end

    // Register writes, capture/clear and interrupt next-state.
    always_comb begin
        wr_en   = chipselect & ~write_n;
        addr_e  = reg_addr_e'(address);
        mask_d  = mask_q;
        ticks_d = ticks_q;
        clr     = '0;
        if (wr_en) begin
            case (addr_e)
                ADDR_MASK:  mask_d  = writedata[N_BUTTONS-1:0];
                ADDR_EDGE:  clr     = writedata[N_BUTTONS-1:0];
                ADDR_TICKS: ticks_d = writedata[CNT_W-1:0];
                default:    ;
            endcase
        end
        // A new edge in the same cycle as its clear keeps the bit set.
        edge_d = (edge_q & ~clr) | hit_w;
        irq_d  = |(edge_q & mask_q);
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (addr_e)
            ADDR_DATA:  readdata_d[N_BUTTONS-1:0] = stable_w;
            ADDR_MASK:  readdata_d[N_BUTTONS-1:0] = mask_q;
            ADDR_EDGE:  readdata_d[N_BUTTONS-1:0] = edge_q;
            ADDR_TICKS: readdata_d[CNT_W-1:0]     = ticks_q;
            default:    ;
        endcase
    end

    // Register file, read data and interrupt flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            edge_q     <= '0;
            ticks_q    <= TICKS_RST;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            ticks_q    <= ticks_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: a falling-edge build (a) and a
// both-edge build (b) share one bus and pin set; expected read data is
// queued when a read is issued and compared when the data returns.
module tb_button_event_ctrl;
    import button_event_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [8:0]  in_port;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        irq_a;
    logic        irq_b;
    logic        sel;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    button_event_ctrl #(
        .N_BUTTONS (9),
        .EDGE_MODE (1)
    ) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_a),
        .in_port    (in_port),
        .irq        (irq_a)
    );

    button_event_ctrl #(
        .N_BUTTONS (9),
        .EDGE_MODE (2)
    ) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_b),
        .in_port    (in_port),
        .irq        (irq_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
        sb_t e;
        address = a;
        e.tag   = tag;
        e.exp   = exp;
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        check(e.tag, sel ? rd_b : rd_a, e.exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'd0, sel ? irq_b : irq_a}, {31'd0, exp});
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 9'h1FF;
        sel        = 1'b0;
        idle(3);
        check("rst_readdata_a", rd_a, 32'h0);
        check("rst_readdata_b", rd_b, 32'h0);
        chk_irq("rst_irq", 1'b0);
        reset_n = 1'b1;

        rd(ADDR_DATA,  "rst_data",  32'h1FF);
        rd(ADDR_MASK,  "rst_mask",  32'h0);
        rd(ADDR_EDGE,  "rst_edge",  32'h0);
        rd(ADDR_TICKS, "rst_ticks", 32'd50000);
        idle(10);
        rd(ADDR_EDGE, "rst_noedge", 32'h0);
        chk_irq("rst_noirq", 1'b0);

        // Clean press on bit 0, first sampled at edge 0; stable moves at
        // edge 5, so registered DATA shows it at edge 6 alongside irq.
        wr(ADDR_TICKS, 32'd4);
        wr(ADDR_MASK,  32'h001);
        in_port = 9'h1FE;
        for (int k = 0; k <= 6; k++) begin
            rd(ADDR_DATA, "press_data", (k >= 6) ? 32'h1FE : 32'h1FF);
            chk_irq("press_irq", k >= 6);
        end
        rd(ADDR_EDGE, "press_edge", 32'h001);

        // Write-1-to-clear: irq drops one cycle after the write.
        wr(ADDR_EDGE, 32'h001);
        chk_irq("w1c_irq_hold", 1'b1);
        tick();
        chk_irq("w1c_irq_drop", 1'b0);
        rd(ADDR_EDGE, "w1c_edge", 32'h0);

        // Release is not an event in falling mode.
        in_port = 9'h1FF;
        idle(8);
        rd(ADDR_EDGE, "rise_ignored", 32'h0);
        chk_irq("rise_no_irq", 1'b0);

        // Re-arm the bit, then collide a new edge with its clear.
        in_port = 9'h1FE;
        idle(8);
        rd(ADDR_EDGE, "repress_edge", 32'h001);
        chk_irq("repress_irq", 1'b1);
        in_port = 9'h1FF;
        idle(8);
        in_port = 9'h1FE;
        idle(5);
        wr(ADDR_EDGE, 32'h001);
        chk_irq("race_irq", 1'b1);
        tick();
        chk_irq("race_irq_next", 1'b1);
        rd(ADDR_EDGE, "race_edge", 32'h001);

        // Bounce: low at edges 0-2, high at 3, low from 4; final low reaches
        // s2 at edge 5, stable at edge 9, DATA read shows it at edge 10.
        in_port = 9'h1FF;
        idle(8);
        wr(ADDR_EDGE, 32'h001);
        tick();
        rd(ADDR_EDGE, "pre_bounce_edge", 32'h0);
        chk_irq("pre_bounce_irq", 1'b0);
        for (int k = 0; k <= 10; k++) begin
            in_port = (k == 3) ? 9'h1FF : 9'h1FE;
            rd(ADDR_DATA, "bounce_data", (k >= 10) ? 32'h1FE : 32'h1FF);
        end
        rd(ADDR_EDGE, "bounce_edge", 32'h001);
        chk_irq("bounce_irq", 1'b1);

        // Lowered threshold mid-count fires on the cycle after the write.
        wr(ADDR_EDGE, 32'h001);
        wr(ADDR_TICKS, 32'd100);
        in_port = 9'h1FF;
        for (int k = 0; k < 20; k++) rd(ADDR_DATA, "thr_hold", 32'h1FE);
        wr(ADDR_TICKS, 32'd10);
        rd(ADDR_DATA, "thr_wait", 32'h1FE);
        rd(ADDR_DATA, "thr_fire", 32'h1FF);
        rd(ADDR_TICKS, "thr_ticks", 32'd10);
        chk_irq("thr_no_irq", 1'b0);

        // Both-edge build: press and release bit 8 with bit 8 masked off.
        reset_n = 1'b0;
        in_port = 9'h1FF;
        idle(2);
        reset_n = 1'b1;
        sel     = 1'b1;
        wr(ADDR_TICKS, 32'd4);
        wr(ADDR_MASK,  32'h0FF);
        in_port = 9'h0FF;
        idle(8);
        rd(ADDR_EDGE, "m2_press_edge", 32'h100);
        chk_irq("m2_masked_press", 1'b0);
        rd(ADDR_DATA, "m2_press_data", 32'h0FF);
        wr(ADDR_EDGE, 32'h100);
        tick();
        rd(ADDR_EDGE, "m2_cleared", 32'h0);
        in_port = 9'h1FF;
        idle(8);
        rd(ADDR_EDGE, "m2_release_edge", 32'h100);
        chk_irq("m2_masked_release", 1'b0);
        rd(ADDR_DATA, "m2_release_data", 32'h1FF);
        wr(ADDR_MASK, 32'h1FF);
        chk_irq("m2_irq_at_mask_write", 1'b0);
        tick();
        chk_irq("m2_irq_unmasked", 1'b1);

        // The falling-edge build saw the same pins but ignored the release.
        sel = 1'b0;
        rd(ADDR_EDGE, "m1_release_ignored", 32'h0);
        chk_irq("m1_no_irq", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
